// File: rtl/collision_scheduler.sv
// Time-multiplexes one shared collision detector across NUM_ENEMIES enemy slots.
// Live slots are serviced in ascending order and results are latched per enemy.
module collision_scheduler #(
  parameter int NUM_ENEMIES = 3,
  parameter int SEL_W       = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NUM_ENEMIES-1:0]   enemy_alive,
  input  logic [9*NUM_ENEMIES-1:0] enemy_x_bus,
  input  logic [8*NUM_ENEMIES-1:0] enemy_y_bus,
  input  logic [3*NUM_ENEMIES-1:0] enemy_dir_bus,
  input  logic [3*NUM_ENEMIES-1:0] enemy_face_bus,
  output logic                     det_init,
  output logic                     det_enable,
  output logic [SEL_W-1:0]         det_sel,
  output logic [8:0]               det_enemy_x,
  output logic [7:0]               det_enemy_y,
  output logic [2:0]               det_enemy_dir,
  output logic [2:0]               det_enemy_face,
  input  logic                     det_done,
  input  logic                     det_c_map,
  input  logic                     det_e_map,
  input  logic                     det_c_e,
  input  logic                     det_hit,
  output logic                     c_map_collision,
  output logic [NUM_ENEMIES-1:0]   e_map_collision,
  output logic [NUM_ENEMIES-1:0]   c_e_collision,
  output logic [NUM_ENEMIES-1:0]   e_hit,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err
);

  localparam int XW = 9;
  localparam int YW = 8;
  localparam int DW = 3;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_LATCH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                 r_state, w_state_n;
  logic [NUM_ENEMIES-1:0] r_alive, w_alive_n;
  logic [SEL_W-1:0]       r_slot, w_slot_n;
  logic                   r_first, w_first_n;
  logic                   r_supp, w_supp_n;
  logic [CW-1:0]          r_cnt, w_cnt_n;
  logic                   r_init, w_init_n;
  logic                   r_en, w_en_n;
  logic [SEL_W-1:0]       r_sel, w_sel_n;
  logic [XW-1:0]          r_x, w_x_n;
  logic [YW-1:0]          r_y, w_y_n;
  logic [DW-1:0]          r_dir, w_dir_n;
  logic [DW-1:0]          r_face, w_face_n;
  logic                   r_cmap, w_cmap_n;
  logic [NUM_ENEMIES-1:0] r_emap, w_emap_n;
  logic [NUM_ENEMIES-1:0] r_ce, w_ce_n;
  logic [NUM_ENEMIES-1:0] r_hit, w_hit_n;
  logic                   r_busy, w_busy_n;
  logic                   r_done, w_done_n;
  logic                   r_to, w_to_n;
  logic                   w_load;
  logic [SEL_W:0]         w_pick;

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [SEL_W:0] find_slot(input logic [NUM_ENEMIES-1:0] mask, input int from);
    logic [SEL_W:0] res;
    res = {1'b0, {SEL_W{1'b0}}};
    for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
      if (mask[i] && (i >= from)) begin
        res = {1'b1, SEL_W'(i)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Next-state and next-output logic for the pass sequencer.
  always_comb begin
    w_state_n = r_state;
    w_alive_n = r_alive;
    w_slot_n  = r_slot;
    w_first_n = r_first;
    w_supp_n  = r_supp;
    w_cnt_n   = r_cnt;
    w_init_n  = 1'b0;
    w_en_n    = 1'b0;
    w_cmap_n  = r_cmap;
    w_emap_n  = r_emap;
    w_ce_n    = r_ce;
    w_hit_n   = r_hit;
    w_busy_n  = r_busy;
    w_done_n  = 1'b0;
    w_to_n    = r_to;
    w_load    = 1'b0;
    w_pick    = {1'b0, {SEL_W{1'b0}}};
    case (r_state)
      S_IDLE: begin
        w_busy_n = 1'b0;
        if (start) begin
          w_pick    = find_slot(enemy_alive, 0);
          w_alive_n = enemy_alive;
          // An empty mask still runs slot 0 so the character/map check happens.
          w_slot_n  = w_pick[SEL_W] ? w_pick[SEL_W-1:0] : {SEL_W{1'b0}};
          w_first_n = 1'b1;
          w_supp_n  = 1'b0;
          w_cmap_n  = 1'b0;
          w_emap_n  = {NUM_ENEMIES{1'b0}};
          w_ce_n    = {NUM_ENEMIES{1'b0}};
          w_hit_n   = {NUM_ENEMIES{1'b0}};
          w_to_n    = 1'b0;
          w_busy_n  = 1'b1;
          w_load    = 1'b1;
          w_state_n = S_LOAD;
        end else begin
          w_state_n = S_IDLE;
        end
      end
      S_LOAD: begin
        w_en_n    = 1'b1;
        w_cnt_n   = CW'(1);
        w_state_n = S_RUN;
      end
      S_RUN: begin
        if (det_done) begin
          w_state_n = S_LATCH;
        end else if (r_cnt >= CW'(TIMEOUT)) begin
          w_supp_n  = 1'b1;
          w_to_n    = 1'b1;
          w_state_n = S_LATCH;
        end else begin
          w_en_n  = 1'b1;
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      S_LATCH: begin
        if (!r_supp && r_first) begin
          w_cmap_n = det_c_map;
        end else begin
          w_cmap_n = r_cmap;
        end
        if (!r_supp && r_alive[r_slot]) begin
          w_emap_n[r_slot] = det_e_map;
          w_ce_n[r_slot]   = det_c_e;
          w_hit_n[r_slot]  = det_hit;
        end else begin
          w_emap_n = r_emap;
        end
        w_first_n = 1'b0;
        w_supp_n  = 1'b0;
        w_pick    = find_slot(r_alive, int'(r_slot) + 1);
        if (w_pick[SEL_W]) begin
          w_slot_n  = w_pick[SEL_W-1:0];
          w_load    = 1'b1;
          w_state_n = S_LOAD;
        end else begin
          w_done_n  = 1'b1;
          w_state_n = S_DONE;
        end
      end
      S_DONE: begin
        w_busy_n  = 1'b0;
        w_state_n = S_IDLE;
      end
      default: begin
        w_busy_n  = 1'b0;
        w_state_n = S_IDLE;
      end
    endcase
  end

  // Operand mux: captures the next slot's fields whenever a LOAD is entered.
  always_comb begin
    w_init_n_unused_guard: begin end
    w_sel_n  = r_sel;
    w_x_n    = r_x;
    w_y_n    = r_y;
    w_dir_n  = r_dir;
    w_face_n = r_face;
    if (w_load) begin
      w_sel_n  = w_slot_n;
      w_x_n    = enemy_x_bus[int'(w_slot_n)*XW +: XW];
      w_y_n    = enemy_y_bus[int'(w_slot_n)*YW +: YW];
      w_dir_n  = enemy_dir_bus[int'(w_slot_n)*DW +: DW];
      w_face_n = enemy_face_bus[int'(w_slot_n)*DW +: DW];
    end else begin
      w_sel_n  = r_sel;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_alive <= {NUM_ENEMIES{1'b0}};
      r_slot  <= {SEL_W{1'b0}};
      r_first <= 1'b0;
      r_supp  <= 1'b0;
      r_cnt   <= {CW{1'b0}};
      r_init  <= 1'b0;
      r_en    <= 1'b0;
      r_sel   <= {SEL_W{1'b0}};
      r_x     <= {XW{1'b0}};
      r_y     <= {YW{1'b0}};
      r_dir   <= {DW{1'b0}};
      r_face  <= {DW{1'b0}};
      r_cmap  <= 1'b0;
      r_emap  <= {NUM_ENEMIES{1'b0}};
      r_ce    <= {NUM_ENEMIES{1'b0}};
      r_hit   <= {NUM_ENEMIES{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_alive <= w_alive_n;
      r_slot  <= w_slot_n;
      r_first <= w_first_n;
      r_supp  <= w_supp_n;
      r_cnt   <= w_cnt_n;
      r_init  <= w_load;
      r_en    <= w_en_n;
      r_sel   <= w_sel_n;
      r_x     <= w_x_n;
      r_y     <= w_y_n;
      r_dir   <= w_dir_n;
      r_face  <= w_face_n;
      r_cmap  <= w_cmap_n;
      r_emap  <= w_emap_n;
      r_ce    <= w_ce_n;
      r_hit   <= w_hit_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
      r_to    <= w_to_n;
    end
  end

  assign det_init        = r_init;
  assign det_enable      = r_en;
  assign det_sel         = r_sel;
  assign det_enemy_x     = r_x;
  assign det_enemy_y     = r_y;
  assign det_enemy_dir   = r_dir;
  assign det_enemy_face  = r_face;
  assign c_map_collision = r_cmap;
  assign e_map_collision = r_emap;
  assign c_e_collision   = r_ce;
  assign e_hit           = r_hit;
  assign busy            = r_busy;
  assign done            = r_done;
  assign timeout_err     = r_to;

endmodule

// File: tb/tb_collision_scheduler.sv
// Self-checking bench for collision_scheduler: directed scenarios plus randomized passes
// checked against a slot-list/latency model; the detector is emulated in the bench.
module tb_collision_scheduler;
  localparam int N  = 3;
  localparam int SW = 2;
  localparam int TO = 8;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [N-1:0]   enemy_alive = '0;
  logic [9*N-1:0] enemy_x_bus = '0;
  logic [8*N-1:0] enemy_y_bus = '0;
  logic [3*N-1:0] enemy_dir_bus = '0;
  logic [3*N-1:0] enemy_face_bus = '0;
  logic           det_done = 1'b0, det_c_map = 1'b0, det_e_map = 1'b0, det_c_e = 1'b0, det_hit = 1'b0;
  logic           det_init, det_enable;
  logic [SW-1:0]  det_sel;
  logic [8:0]     det_enemy_x;
  logic [7:0]     det_enemy_y;
  logic [2:0]     det_enemy_dir, det_enemy_face;
  logic           c_map_collision;
  logic [N-1:0]   e_map_collision, c_e_collision, e_hit;
  logic           busy, done, timeout_err;

  int   nvec = 0;
  int   nerr = 0;
  int   k_plan [N];
  logic cm_plan[N], em_plan[N], ce_plan[N], hit_plan[N];
  int   lat;

  collision_scheduler #(.NUM_ENEMIES(N), .SEL_W(SW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .start(start), .enemy_alive(enemy_alive),
    .enemy_x_bus(enemy_x_bus), .enemy_y_bus(enemy_y_bus),
    .enemy_dir_bus(enemy_dir_bus), .enemy_face_bus(enemy_face_bus),
    .det_init(det_init), .det_enable(det_enable), .det_sel(det_sel),
    .det_enemy_x(det_enemy_x), .det_enemy_y(det_enemy_y),
    .det_enemy_dir(det_enemy_dir), .det_enemy_face(det_enemy_face),
    .det_done(det_done), .det_c_map(det_c_map), .det_e_map(det_e_map),
    .det_c_e(det_c_e), .det_hit(det_hit),
    .c_map_collision(c_map_collision), .e_map_collision(e_map_collision),
    .c_e_collision(c_e_collision), .e_hit(e_hit),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({det_init, det_enable, det_sel, det_enemy_x, det_enemy_y, det_enemy_dir,
                det_enemy_face, c_map_collision, e_map_collision, c_e_collision, e_hit,
                busy, done, timeout_err});
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_plan(input int k, input logic [N-1:0] cm, input logic [N-1:0] em,
                          input logic [N-1:0] ce, input logic [N-1:0] hit);
    for (int i = 0; i < N; i++) begin
      k_plan[i] = k; cm_plan[i] = cm[i]; em_plan[i] = em[i]; ce_plan[i] = ce[i]; hit_plan[i] = hit[i];
    end
  endtask

  // One full pass: model predicts slot order, latency and results; bench plays the detector.
  task automatic run_pass(input logic [N-1:0] alive, input bit hold, input bit stray, output int l);
    int exp_sel[$];
    int en_cnt[N];
    int exp_lat, nload, rc, cur, s, runk;
    bit to_s, exp_to, seen;
    logic exp_cm;
    logic [N-1:0] exp_em, exp_ce, exp_hit;
    exp_to = 0; exp_cm = 1'b0; exp_em = '0; exp_ce = '0; exp_hit = '0;
    for (int i = 0; i < N; i++) begin
      en_cnt[i] = 0;
      if (alive[i]) exp_sel.push_back(i);
    end
    if (exp_sel.size() == 0) exp_sel.push_back(0);
    exp_lat = 1;
    for (int j = 0; j < exp_sel.size(); j++) begin
      s = exp_sel[j];
      to_s = (k_plan[s] == 0) || (k_plan[s] > TO);
      exp_lat += (to_s ? TO : k_plan[s]) + 2;
      if (to_s) exp_to = 1;
      else begin
        if (j == 0) exp_cm = cm_plan[s];
        if (alive[s]) begin
          exp_em[s] = em_plan[s]; exp_ce[s] = ce_plan[s]; exp_hit[s] = hit_plan[s];
        end
      end
    end
    enemy_x_bus    = 27'($urandom);
    enemy_y_bus    = 24'($urandom);
    enemy_dir_bus  = 9'($urandom);
    enemy_face_bus = 9'($urandom);
    enemy_alive    = alive;
    start          = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    enemy_alive = ~alive;
    chk("clear_at_start", 64'({c_map_collision, e_map_collision, c_e_collision, e_hit, timeout_err}), 64'd0);
    l = 1; nload = 0; cur = 0; rc = 0; seen = 0;
    while (!seen && l <= exp_lat + 4) begin
      chk("busy_in_pass", 64'(busy), 64'd1);
      if (det_init === 1'b1) begin
        cur = (nload < exp_sel.size()) ? exp_sel[nload] : 0;
        chk("det_sel", 64'(det_sel), 64'(cur));
        chk("op_x", 64'(det_enemy_x), 64'(enemy_x_bus[cur*9 +: 9]));
        chk("op_y", 64'(det_enemy_y), 64'(enemy_y_bus[cur*8 +: 8]));
        chk("op_dir", 64'(det_enemy_dir), 64'(enemy_dir_bus[cur*3 +: 3]));
        chk("op_face", 64'(det_enemy_face), 64'(enemy_face_bus[cur*3 +: 3]));
        nload++; rc = 0;
        det_c_map = cm_plan[cur]; det_e_map = em_plan[cur];
        det_c_e = ce_plan[cur]; det_hit = hit_plan[cur];
        det_done = stray && (nload == 1);
      end else if (det_enable === 1'b1) begin
        rc++; en_cnt[cur]++;
        det_done = (rc == k_plan[cur]);
      end else begin
        det_done = 1'b0;
      end
      if (done === 1'b1) seen = 1;
      else begin
        tick();
        l++;
      end
    end
    chk("latency", 64'(l), 64'(exp_lat));
    chk("num_slots", 64'(nload), 64'(exp_sel.size()));
    chk("c_map", 64'(c_map_collision), 64'(exp_cm));
    chk("e_map", 64'(e_map_collision), 64'(exp_em));
    chk("c_e", 64'(c_e_collision), 64'(exp_ce));
    chk("e_hit", 64'(e_hit), 64'(exp_hit));
    chk("timeout_err", 64'(timeout_err), 64'(exp_to));
    for (int j = 0; j < exp_sel.size(); j++) begin
      s = exp_sel[j];
      runk = ((k_plan[s] == 0) || (k_plan[s] > TO)) ? TO : k_plan[s];
      chk("run_cycles", 64'(en_cnt[s]), 64'(runk));
    end
    det_done = 1'b0;
    tick();
    chk("idle_after_done", 64'({busy, done}), 64'd0);
    chk("results_hold", 64'({c_map_collision, e_map_collision, c_e_collision, e_hit}),
        64'({exp_cm, exp_em, exp_ce, exp_hit}));
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk("reset_state", all_outs(), 64'd0);
    reset = 1'b1;
    tick();

    // alive=111, done in RUN cycle 1, slot1 c_e and slot2 hit
    set_plan(1, 3'b101, 3'b000, 3'b010, 3'b100);
    run_pass(3'b111, 0, 0, lat);
    chk("lat_111", 64'(lat), 64'd10);
    chk("ce_111", 64'(c_e_collision), 64'b010);
    chk("hit_111", 64'(e_hit), 64'b100);

    // alive=101: slot 1 skipped
    set_plan(1, 3'b111, 3'b111, 3'b111, 3'b111);
    run_pass(3'b101, 0, 0, lat);
    chk("lat_101", 64'(lat), 64'd7);
    chk("slot1_untouched", 64'({e_map_collision[1], c_e_collision[1], e_hit[1]}), 64'd0);

    // alive=000: char-only pass on slot 0
    set_plan(2, 3'b001, 3'b111, 3'b111, 3'b111);
    k_plan[0] = 1;
    run_pass(3'b000, 0, 0, lat);
    chk("lat_000", 64'(lat), 64'd4);
    chk("cmap_000", 64'(c_map_collision), 64'd1);
    chk("enemy_000", 64'({e_map_collision, c_e_collision, e_hit}), 64'd0);

    // timeout on slot 0, others still serviced
    set_plan(1, 3'b111, 3'b111, 3'b111, 3'b111);
    k_plan[0] = 0; k_plan[2] = 2;
    run_pass(3'b111, 0, 0, lat);
    chk("lat_timeout", 64'(lat), 64'd18);
    chk("timeout_set", 64'(timeout_err), 64'd1);
    chk("slot0_zero", 64'({e_map_collision[0], c_e_collision[0], e_hit[0]}), 64'd0);

    // next start clears timeout_err
    set_plan(2, 3'b010, 3'b011, 3'b001, 3'b110);
    run_pass(3'b011, 0, 0, lat);
    chk("timeout_cleared", 64'(timeout_err), 64'd0);

    // start held through a pass with stray det_done in LOAD, then back-to-back pass
    set_plan(3, 3'b100, 3'b110, 3'b010, 3'b100);
    run_pass(3'b110, 1, 1, lat);
    chk("lat_hold", 64'(lat), 64'd11);
    run_pass(3'b001, 0, 0, lat);
    chk("lat_back2back", 64'(lat), 64'd6);

    // reset mid-RUN aborts the pass without done
    set_plan(0, 3'b111, 3'b111, 3'b111, 3'b111);
    enemy_alive = 3'b111;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_reset_run", 64'(det_enable), 64'd1);
    reset = 1'b0;
    tick();
    chk("reset_mid_run_1", all_outs(), 64'd0);
    tick();
    chk("reset_mid_run_2", all_outs(), 64'd0);
    reset = 1'b1;
    tick();
    chk("no_done_after_reset", 64'({busy, done}), 64'd0);
    tick();
    chk("still_idle", 64'({busy, done}), 64'd0);
    set_plan(2, 3'b011, 3'b101, 3'b110, 3'b011);
    run_pass(3'b111, 0, 0, lat);

    // randomized passes
    for (int p = 0; p < 25; p++) begin
      for (int i = 0; i < N; i++) begin
        int v;
        v = int'($urandom_range(0, 9));
        k_plan[i]   = (v == 0) ? 0 : (v % 4) + 1;
        cm_plan[i]  = 1'($urandom);
        em_plan[i]  = 1'($urandom);
        ce_plan[i]  = 1'($urandom);
        hit_plan[i] = 1'($urandom);
      end
      run_pass(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), lat);
    end
    start = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/collision_scheduler.md
Name: collision_scheduler

Overview:
Time-multiplexes one shared collision_detector across NUM_ENEMIES enemy slots, replacing one detector instance per enemy. On each start it latches an alive mask and walks the live slots in ascending order. For each slot it drives that enemy's operands to the detector, runs the detector, and latches the results into per-enemy registers. It then pulses done to game control, and sits between game control and the shared detector.

Parameters:
NUM_ENEMIES, 3, number of enemy slots (1..4)
SEL_W, 2, width of the slot index
TIMEOUT, 1023, maximum RUN cycles to wait for det_done before aborting a slot

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
start  in  1  one-cycle request to run a full collision pass (accepted only in IDLE)
enemy_alive  in  NUM_ENEMIES  per-slot alive mask, sampled on accepted start
enemy_x_bus  in  9*NUM_ENEMIES  packed enemy x, slot i at [9i+8:9i]
enemy_y_bus  in  8*NUM_ENEMIES  packed enemy y
enemy_dir_bus  in  3*NUM_ENEMIES  packed enemy direction
enemy_face_bus  in  3*NUM_ENEMIES  packed enemy facing
det_init  out  1  one-cycle init pulse to the detector
det_enable  out  1  detector collision_enable
det_sel  out  SEL_W  slot currently being serviced
det_enemy_x  out  9  registered operand to detector
det_enemy_y  out  8  registered operand
det_enemy_dir  out  3  registered operand
det_enemy_face  out  3  registered operand
det_done  in  1  detector finished
det_c_map  in  1  detector char-map collision
det_e_map  in  1  detector enemy-map collision
det_c_e  in  1  detector char-enemy collision
det_hit  in  1  detector enemy-hit
c_map_collision  out  1  char map collision, latched from first serviced slot
e_map_collision  out  NUM_ENEMIES  per-slot result
c_e_collision  out  NUM_ENEMIES  per-slot result
e_hit  out  NUM_ENEMIES  per-slot result
busy  out  1  high from LOAD of first slot through DONE
done  out  1  one-cycle pulse at end of pass
timeout_err  out  1  sticky; set if any slot timed out this pass

Behaviour:
- All outputs are registered. On reset low at any clock edge, every output goes to 0, state goes to IDLE, and counters clear. A reset mid-pass aborts with no done pulse.
- States are IDLE, LOAD, RUN, LATCH and DONE.
- IDLE: a start accepted at edge N does the following:
  - latches enemy_alive into alive_q;
  - clears all result outputs and timeout_err;
  - selects the lowest set bit of alive_q;
  - enters LOAD in cycle N+1.
- IDLE with alive_q == 0: slot 0 is serviced as a char-only pass. Only c_map_collision is latched and all enemy results stay 0.
- start is ignored while not in IDLE, and enemy_alive changes mid-pass are ignored.
- LOAD (1 cycle):
  - det_sel = slot, and det_enemy_* = that slot's fields, held stable until the next LOAD;
  - det_init = 1 and det_enable = 0.
- RUN:
  - det_enable = 1; a timeout counter counts RUN cycles starting at 1.
  - If det_done is sampled high in RUN cycle k, move to LATCH.
  - If the counter reaches TIMEOUT without det_done: set timeout_err, leave that slot's results at 0, move to LATCH with a capture-suppress flag.
- LATCH (1 cycle):
  - det_enable = 0.
  - Unless suppressed, write det_e_map, det_c_e and det_hit into bit [slot] of the result outputs.
  - det_c_map is written to c_map_collision only for the first serviced slot of the pass.
  - Next state is LOAD with the next higher set bit of alive_q; if none remains, DONE.
- DONE (1 cycle): done = 1, busy = 1, then IDLE. Results hold until the next accepted start.
- det_done outside RUN is ignored.
- Slot cost is k+2 cycles: LOAD, plus k RUN cycles, plus LATCH.
- Pass latency from the start edge to the done cycle is 1 + sum(k_i + 2) over serviced slots.

Test Plan:
- Reset low for 2 cycles mid-RUN -> all outputs 0 next cycle, state IDLE, no done pulse; a start after release runs a normal pass.
- alive=3'b111, detector returns det_done in RUN cycle 1, with slot1 det_c_e=1 and slot2 det_hit=1:
  - det_sel sequence is 0,1,2;
  - done is high exactly at cycle 10 after the start edge;
  - c_e_collision=3'b010 and e_hit=3'b100.
- alive=3'b101 -> slot 1 is never selected (det_sel sequence 0,2), e_*[1] stays 0, done at cycle 7.
- alive=3'b000, det_c_map=1 -> only slot 0 is serviced, c_map_collision=1, all per-enemy results 0, done at cycle 4.
- TIMEOUT=8, detector never asserts done on slot 0 -> det_enable drops after 8 RUN cycles, timeout_err=1, slot 0 results 0, remaining slots still serviced. The next start clears timeout_err.
- start held high through a whole pass, plus a stray det_done during LOAD -> only one pass runs, the stray det_done has no effect, and a second pass starts at the first IDLE cycle after DONE.
